motor_pwm_drive: RTL and testbench
==================================

Name: motor_pwm_drive

Overview:
- Downstream stage of the position-error block; consumes errorabs/errorsign and drives the motor H-bridge.
- Proportional control: duty = MIN_DUTY + KP*errorabs, saturated to the period; direction from errorsign.
- Brake dead-time inserted on every direction reversal; duty updated only at PWM period boundaries (glitch-free).
- Reports on_target after a run of in-deadband periods.

Parameters:
- ERR_W, 12, width of errorabs
- PWM_PERIOD, 2400, clk_48 cycles per PWM period (20 kHz)
- KP, 8, integer proportional gain (1..255)
- MIN_DUTY, 200, duty offset added when outside deadband (overcomes stiction)
- DEADBAND, 2, errorabs <= DEADBAND gives duty 0
- DEAD_CYCLES, 480, brake cycles on reversal (10 us)
- ON_TGT_PERIODS, 4, consecutive in-deadband periods before on_target asserts

Ports:
- clk_48  in  1  system clock, 48 MHz
- reset  in  1  synchronous, active-high reset
- enable  in  1  drive enable; low forces IDLE
- errorabs  in  ERR_W  |position error| from the error stage
- errorsign  in  1  1 = negative error (drive reverse)
- pwm_out  out  1  H-bridge PWM, registered
- dir_out  out  1  H-bridge direction, registered
- brake  out  1  high during reversal dead-time
- period_strobe  out  1  one-cycle pulse on the last cycle of each RUN period
- on_target  out  1  position settled

Behaviour:
- Reset (synchronous, reset=1 at a clk_48 edge): state IDLE, cnt=0, duty_reg=0, dead_cnt=0, tgt_cnt=0; all outputs 0. Reset overrides every state, including DEAD mid-count.
- duty_calc: if errorabs <= DEADBAND then 0, else min(MIN_DUTY + KP*errorabs, PWM_PERIOD). Product is ERR_W+8 bits; sum is one bit wider; no wrap permitted.
- FSM states: IDLE, RUN, DEAD. enable=0 in any state -> IDLE on the next edge.
- IDLE: pwm_out=0, brake=0, cnt=0, dir_out holds. enable=1 -> RUN with cnt=0. duty_reg loads duty_calc. dir_out loads errorsign (no dead-time from IDLE).
- RUN:
  - cnt counts 0..PWM_PERIOD-1 and wraps.
  - pwm_out(t+1) = (cnt(t) < duty_reg(t)); one-cycle registered latency.
  - period_strobe=1 when cnt==PWM_PERIOD-1.
  - Inputs are sampled only on the strobe cycle:
    - d = duty_calc.
    - If d>0 and errorsign != dir_out -> DEAD; latch d and sign; dead_cnt=0.
    - Otherwise duty_reg<=d, effective from cnt=0.
    - If d==0 and the sign differs: no reversal, dir_out holds.
- DEAD: pwm_out=0, brake=1, dead_cnt increments. On dead_cnt==DEAD_CYCLES-1: dir_out<=latched sign, duty_reg<=latched d, cnt<=0, brake<=0, -> RUN. Input changes during DEAD are ignored until the next RUN strobe.
- on_target:
  - On each RUN strobe, tgt_cnt increments (saturating at ON_TGT_PERIODS) if errorabs<=DEADBAND, else clears to 0.
  - on_target = (tgt_cnt==ON_TGT_PERIODS).
  - Cleared in IDLE and DEAD.
- duty_reg==PWM_PERIOD gives pwm_out continuously high. duty_reg==0 gives pwm_out continuously low.
- enable dropping mid-period: pwm_out=0 on the following edge; no partial-period completion.

Decomposition:
- Package motor_pkg:
  - CLK_HZ=48_000_000
  - default PWM_PERIOD, DEAD_CYCLES, DEADBAND
  - FSM state enum {IDLE, RUN, DEAD}
  - ERR_W
- Sub-module motor_duty_calc (combinational deadband + scale + saturate; parameters KP, MIN_DUTY, DEADBAND, PWM_PERIOD). Unit-tested separately.
- FSM, counters and output registers stay in motor_pwm_drive.

Test Plan:
- reset=1 then enable=1, errorabs=50, errorsign=0 -> duty 600; pwm_out high exactly 600 of every 2400 cycles; dir_out=0; period_strobe every 2400 cycles.
- errorabs=300 -> 200+2400 saturates to 2400 -> pwm_out constantly 1. errorabs=4095 -> same, no wrap.
- errorabs=2 held -> pwm_out=0; on_target rises at the 4th strobe. errorabs=3 at the next strobe -> on_target falls; duty becomes 224.
- Running at 600, errorsign 0->1 mid-period -> current period completes at 600. Then brake=1 and pwm_out=0 for exactly 480 cycles. Then dir_out=1 and pwm resumes at 600 from cnt=0.
- enable 1->0 at cnt=100 -> pwm_out=0 next cycle, state IDLE, dir_out unchanged. Re-enable -> period restarts at cnt=0.
- reset=1 at dead_cnt=200 in DEAD -> next edge: all outputs 0, dir_out=0, state IDLE.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared constants and FSM state type for the motor PWM drive.
package motor_pkg;

  localparam int CLK_HZ          = 48_000_000;
  localparam int DEF_ERR_W       = 12;
  localparam int DEF_PWM_PERIOD  = 2400;
  localparam int DEF_DEAD_CYCLES = 480;
  localparam int DEF_DEADBAND    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } motor_state_e;

endpackage

// File: rtl/motor_duty_calc.sv
// Combinational duty computation: deadband, proportional scale, saturation to one period.
module motor_duty_calc
  import motor_pkg::*;
#(
  parameter int ERR_W      = DEF_ERR_W,
  parameter int KP         = 8,
  parameter int MIN_DUTY   = 200,
  parameter int DEADBAND   = DEF_DEADBAND,
  parameter int PWM_PERIOD = DEF_PWM_PERIOD,
  parameter int DUTY_W     = $clog2(DEF_PWM_PERIOD + 1)
) (
  input  logic [ERR_W-1:0]  errorabs,
  output logic [DUTY_W-1:0] duty
);

  // KP is at most 8 bits wide; the extra sum bit keeps MIN_DUTY from wrapping
  localparam int PROD_W = ERR_W + 8;
  localparam int SUM_W  = ERR_W + 9;

  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum;

  // Clamp the raw command to a full period so the drive never sees a wrapped duty
  function automatic logic [DUTY_W-1:0] sat_period(input logic [SUM_W-1:0] s);
    if (s > SUM_W'(PWM_PERIOD))
      return DUTY_W'(PWM_PERIOD);
    else
      return DUTY_W'(s);
  endfunction

  // Deadband gives zero drive; otherwise offset plus proportional term, saturated
  always_comb begin
    prod = PROD_W'(errorabs) * PROD_W'(KP);
    sum  = SUM_W'(prod) + SUM_W'(MIN_DUTY);
    if (errorabs <= ERR_W'(DEADBAND))
      duty = '0;
    else
      duty = sat_period(sum);
  end

endmodule

// File: rtl/motor_pwm_drive.sv
// H-bridge PWM drive: proportional duty, reversal dead-time, on-target detection.
module motor_pwm_drive
  import motor_pkg::*;
#(
  parameter int ERR_W          = DEF_ERR_W,
  parameter int PWM_PERIOD     = DEF_PWM_PERIOD,
  parameter int KP             = 8,
  parameter int MIN_DUTY       = 200,
  parameter int DEADBAND       = DEF_DEADBAND,
  parameter int DEAD_CYCLES    = DEF_DEAD_CYCLES,
  parameter int ON_TGT_PERIODS = 4
) (
  input  logic             clk_48,
  input  logic             reset,
  input  logic             enable,
  input  logic [ERR_W-1:0] errorabs,
  input  logic             errorsign,
  output logic             pwm_out,
  output logic             dir_out,
  output logic             brake,
  output logic             period_strobe,
  output logic             on_target
);

  localparam int CNT_W  = $clog2(PWM_PERIOD);
  localparam int DUTY_W = $clog2(PWM_PERIOD + 1);
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int TGT_W  = $clog2(ON_TGT_PERIODS + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_PERIOD - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [TGT_W-1:0]  TGT_MAX   = TGT_W'(ON_TGT_PERIODS);

  motor_state_e state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [DUTY_W-1:0] duty_calc;
  logic [DUTY_W-1:0] duty_reg;
  logic [DUTY_W-1:0] duty_lat;
  logic              sign_lat;
  logic [DEAD_W-1:0] dead_cnt;
  logic [TGT_W-1:0]  tgt_cnt;
  logic              strobe;
  logic              in_band;
  logic              reverse;
  logic              dead_done;

  motor_duty_calc #(
    .ERR_W      (ERR_W),
    .KP         (KP),
    .MIN_DUTY   (MIN_DUTY),
    .DEADBAND   (DEADBAND),
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_W     (DUTY_W)
  ) u_duty_calc (
    .errorabs (errorabs),
    .duty     (duty_calc)
  );

  // Inputs only matter on the last cycle of a RUN period
  assign strobe    = (state == RUN) && (cnt == CNT_LAST);
  assign in_band   = (errorabs <= ERR_W'(DEADBAND));
  assign reverse   = strobe && (duty_calc != '0) && (errorsign != dir_out);
  assign dead_done = (dead_cnt == DEAD_LAST);

  assign period_strobe = strobe;
  assign on_target     = (state == RUN) && (tgt_cnt == TGT_MAX);

  // State register
  always_ff @(posedge clk_48) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state: enable low always wins; reversal only at a period boundary
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (reverse) state_nxt = DEAD;
      DEAD:    if (dead_done) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!enable)
      state_nxt = IDLE;
  end

  // Counters, latched duty/direction and registered H-bridge outputs
  always_ff @(posedge clk_48) begin
    if (reset) begin
      cnt      <= '0;
      duty_reg <= '0;
      duty_lat <= '0;
      sign_lat <= 1'b0;
      dead_cnt <= '0;
      tgt_cnt  <= '0;
      pwm_out  <= 1'b0;
      dir_out  <= 1'b0;
      brake    <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
      dead_cnt <= '0;
      tgt_cnt  <= '0;
      pwm_out  <= 1'b0;
      brake    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          tgt_cnt  <= '0;
          pwm_out  <= 1'b0;
          brake    <= 1'b0;
          duty_reg <= duty_calc;
          dir_out  <= errorsign;
        end
        RUN: begin
          cnt <= strobe ? '0 : cnt + 1'b1;
          if (reverse) begin
            pwm_out  <= 1'b0;
            brake    <= 1'b1;
            dead_cnt <= '0;
            duty_lat <= duty_calc;
            sign_lat <= errorsign;
            tgt_cnt  <= '0;
          end else begin
            pwm_out <= (DUTY_W'(cnt) < duty_reg);
            if (strobe) begin
              duty_reg <= duty_calc;
              if (!in_band)
                tgt_cnt <= '0;
              else if (tgt_cnt != TGT_MAX)
                tgt_cnt <= tgt_cnt + 1'b1;
            end
          end
        end
        DEAD: begin
          pwm_out  <= 1'b0;
          tgt_cnt  <= '0;
          dead_cnt <= dead_cnt + 1'b1;
          if (dead_done) begin
            dir_out  <= sign_lat;
            duty_reg <= duty_lat;
            cnt      <= '0;
            brake    <= 1'b0;
          end
        end
        default: begin
          cnt     <= '0;
          pwm_out <= 1'b0;
          brake   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Scoreboard bench for motor_pwm_drive: period-level duty, saturation, deadband, reversal, enable, reset.
module tb_motor_pwm_drive;

  localparam int PER   = 2400;
  localparam int DEADC = 480;

  logic        clk_48 = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] errorabs = 12'd0;
  logic        errorsign = 1'b0;
  logic        pwm_out, dir_out, brake, period_strobe, on_target;

  motor_pwm_drive dut (
    .clk_48        (clk_48),
    .reset         (reset),
    .enable        (enable),
    .errorabs      (errorabs),
    .errorsign     (errorsign),
    .pwm_out       (pwm_out),
    .dir_out       (dir_out),
    .brake         (brake),
    .period_strobe (period_strobe),
    .on_target     (on_target)
  );

  always #5 clk_48 = ~clk_48;

  typedef struct {
    string tag;
    int    val;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  cur_duty = 0;
  int  m_tgt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.val);
    end else begin
      chk("sb_underflow", 0, 1);
    end
  endtask

  function automatic int ref_duty(input int e);
    int raw;
    if (e <= 2) return 0;
    raw = 200 + 8 * e;
    return (raw > PER) ? PER : raw;
  endfunction

  // Samples after a strobe see cnt 2399 of the old duty, then cnt 0..2398 of the new one
  function automatic int win_hi(input int old_d, input int new_d);
    return ((PER - 1) < old_d ? 1 : 0) + ((new_d < PER - 1) ? new_d : PER - 1);
  endfunction

  task automatic wait_strobe(output int k);
    k = 0;
    while (k < 5000) begin
      @(negedge clk_48);
      k++;
      if (period_strobe) break;
    end
  endtask

  // Called at a strobe negedge; drives the new error and checks the following period
  task automatic run_period(input int new_abs, input int flip_at, input string tag);
    int nd, hi, st, tf;
    errorabs = 12'(new_abs);
    nd = ref_duty(new_abs);
    m_tgt = (new_abs <= 2) ? ((m_tgt < 4) ? m_tgt + 1 : 4) : 0;
    sb_push({tag, "_hi"}, win_hi(cur_duty, nd));
    sb_push({tag, "_strobes"}, 1);
    sb_push({tag, "_on_target"}, (m_tgt == 4) ? 1 : 0);
    cur_duty = nd;
    hi = 0; st = 0; tf = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk_48);
      if (i == 0) tf = int'(on_target);
      hi += int'(pwm_out);
      st += int'(period_strobe);
      if (i == flip_at) errorsign = 1'b1;
    end
    sb_pop(hi);
    sb_pop(st);
    sb_pop(tf);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, hi, st;

    // Reset state
    reset = 1'b1; enable = 1'b0; errorabs = 12'd50; errorsign = 1'b0;
    repeat (3) @(negedge clk_48);
    sb_push("rst_pwm", 0);    sb_pop(int'(pwm_out));
    sb_push("rst_dir", 0);    sb_pop(int'(dir_out));
    sb_push("rst_brake", 0);  sb_pop(int'(brake));
    sb_push("rst_strobe", 0); sb_pop(int'(period_strobe));
    sb_push("rst_ontgt", 0);  sb_pop(int'(on_target));
    reset = 1'b0;
    @(negedge clk_48);

    // Forward drive at 600
    enable = 1'b1;
    cur_duty = ref_duty(50);
    m_tgt = 0;
    sb_push("first_strobe_latency", PER);
    wait_strobe(k);
    sb_pop(k);
    run_period(50, -1, "p600a");
    run_period(50, -1, "p600b");
    sb_push("dir_fwd", 0); sb_pop(int'(dir_out));

    // Saturation
    run_period(300, -1, "sat300a");
    run_period(300, -1, "sat300b");
    run_period(4095, -1, "sat4095");

    // Deadband and on_target
    run_period(2, -1, "db0");
    run_period(2, -1, "db1");
    run_period(2, -1, "db2");
    run_period(2, -1, "db3");
    run_period(3, -1, "db_exit");

    // Reversal request mid-period
    run_period(50, -1, "back600");
    run_period(50, 1000, "rev_pre");
    sb_push("dead_len", DEADC);
    sb_push("dead_pwm", 0);
    k = 0; hi = 0;
    while (k < 1000) begin
      @(negedge clk_48);
      if (!brake) break;
      k++;
      hi += int'(pwm_out);
    end
    sb_pop(k);
    sb_pop(hi);
    sb_push("dir_rev", 1); sb_pop(int'(dir_out));
    sb_push("rev_post_hi", 600);
    sb_push("rev_post_strobes", 1);
    hi = 0; st = 0;
    for (int i = 0; i < PER - 1; i++) begin
      @(negedge clk_48);
      hi += int'(pwm_out);
      st += int'(period_strobe);
    end
    sb_pop(hi);
    sb_pop(st);

    // Enable drop at cnt=100
    repeat (101) @(negedge clk_48);
    sb_push("pwm_before_drop", 1); sb_pop(int'(pwm_out));
    enable = 1'b0;
    @(negedge clk_48);
    sb_push("pwm_after_drop", 0); sb_pop(int'(pwm_out));
    sb_push("dir_hold", 1);       sb_pop(int'(dir_out));
    sb_push("brake_idle", 0);     sb_pop(int'(brake));
    hi = 0; st = 0;
    repeat (50) begin
      @(negedge clk_48);
      hi += int'(pwm_out);
      st += int'(period_strobe);
    end
    sb_push("idle_pwm", 0);     sb_pop(hi);
    sb_push("idle_strobes", 0); sb_pop(st);
    enable = 1'b1;
    sb_push("reenable_latency", PER);
    wait_strobe(k);
    sb_pop(k);

    // Reversal into DEAD, then reset at dead_cnt=200
    errorsign = 1'b0;
    repeat (201) @(negedge clk_48);
    sb_push("brake_before_reset", 1); sb_pop(int'(brake));
    reset = 1'b1;
    @(negedge clk_48);
    sb_push("dead_rst_pwm", 0);    sb_pop(int'(pwm_out));
    sb_push("dead_rst_dir", 0);    sb_pop(int'(dir_out));
    sb_push("dead_rst_brake", 0);  sb_pop(int'(brake));
    sb_push("dead_rst_strobe", 0); sb_pop(int'(period_strobe));
    sb_push("dead_rst_ontgt", 0);  sb_pop(int'(on_target));
    reset = 1'b0;
    sb_push("post_reset_latency", PER);
    wait_strobe(k);
    sb_pop(k);

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
